spi_regif: RTL and testbench

Parametrised SPI slave to register-bus bridge, the next generation of our byte-wide SPI slave. It supports all four SPI modes, configurable word and address widths, a read/write command bit, and optional address auto-increment. Read data is prefetched so that multi-word bursts run back-to-back. It sits between the external SPI pads and the internal register bus of the control plane, and runs entirely in the system clock domain; SPI pins are oversampled.

---
 rtl/spi_regif.sv | 169 ++++++++++++++++
 tb/tb_spi_regif.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regif.sv
// SPI slave to register-bus bridge: oversampled SPI pins, all four modes, DW-bit words with read prefetch.
// Optional address auto-increment is enabled by defining SPI_REGIF_AUTOINC_EN.
module spi_regif #(
  parameter int DW   = 8,
  parameter int AW   = 7,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spi_clk,
  input  logic          spi_cs_n,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_we,
  output logic          bus_re,
  input  logic [DW-1:0] bus_rdata,
  output logic          frame_err
);

  localparam int CW = $clog2(DW);
  localparam bit SAMPLE_RISE = (CPOL == CPHA);
  localparam logic [2:0] SYNC_RST = {CPOL, 1'b1, 1'b0};
`ifdef SPI_REGIF_AUTOINC_EN
  localparam logic [AW-1:0] ADDR_INC = AW'(1);
`else
  localparam logic [AW-1:0] ADDR_INC = '0;
`endif

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  logic [2:0]    pad_in, sync1_reg, sync2_reg;
  logic          sclk_s, cs_s, mosi_s;
  logic          sclk_prev_reg, cs_prev_reg, mosi_d_reg;
  logic          sample_pulse_reg, shift_pulse_reg, cs_fall_reg, cs_rise_reg;
  logic [1:0]    settle_reg;
  logic          armed_reg;
  logic          sclk_rise, sclk_fall;

  state_t        state_reg;
  logic [CW-1:0] bit_cnt_reg, cnt_next;
  logic [DW-2:0] rx_shift_reg;
  logic [DW-1:0] tx_shift_reg, rx_word;
  logic [1:0]    re_pipe_reg;
  logic          word_done;

  assign pad_in = {spi_clk, spi_cs_n, spi_mosi};
  assign sclk_s = sync2_reg[2];
  assign cs_s   = sync2_reg[1];
  assign mosi_s = sync2_reg[0];
  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_s & sclk_prev_reg;
  assign spi_miso_oe = ~cs_s;

  // Synchronisers and registered edge detectors; mosi is delayed one more flop to line up with the sample pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg        <= SYNC_RST;
      sync2_reg        <= SYNC_RST;
      sclk_prev_reg    <= CPOL;
      cs_prev_reg      <= 1'b1;
      mosi_d_reg       <= 1'b0;
      sample_pulse_reg <= 1'b0;
      shift_pulse_reg  <= 1'b0;
      cs_fall_reg      <= 1'b0;
      cs_rise_reg      <= 1'b0;
      settle_reg       <= 2'b00;
      armed_reg        <= 1'b0;
    end else begin
      sync1_reg        <= pad_in;
      sync2_reg        <= sync1_reg;
      sclk_prev_reg    <= sclk_s;
      cs_prev_reg      <= cs_s;
      mosi_d_reg       <= mosi_s;
      sample_pulse_reg <= SAMPLE_RISE ? sclk_rise : sclk_fall;
      shift_pulse_reg  <= SAMPLE_RISE ? sclk_fall : sclk_rise;
      // A frame already running when reset releases is ignored: CS must be seen high first.
      cs_fall_reg      <= cs_prev_reg & ~cs_s & armed_reg;
      cs_rise_reg      <= ~cs_prev_reg & cs_s;
      settle_reg       <= {settle_reg[0], 1'b1};
      if (settle_reg[1] && cs_s)
        armed_reg <= 1'b1;
    end
  end

  assign rx_word   = {rx_shift_reg, mosi_d_reg};
  assign word_done = sample_pulse_reg && (state_reg != IDLE) && (bit_cnt_reg == CW'(DW - 1));
  assign cnt_next  = sample_pulse_reg ? bit_cnt_reg + CW'(1) : bit_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      rx_shift_reg <= '0;
      tx_shift_reg <= '0;
      re_pipe_reg  <= 2'b00;
      spi_miso     <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_we       <= 1'b0;
      bus_re       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      bus_we      <= 1'b0;
      bus_re      <= 1'b0;
      frame_err   <= 1'b0;
      re_pipe_reg <= {re_pipe_reg[0], bus_re};
      if (bus_we)
        bus_addr <= bus_addr + ADDR_INC;
      if (state_reg != IDLE && sample_pulse_reg) begin
        rx_shift_reg <= rx_word[DW-2:0];
        bit_cnt_reg  <= bit_cnt_reg + CW'(1);
      end
      // With CPHA=0 the shift edge right after a word's last sample must keep the freshly loaded MSB.
      if (state_reg == RD && shift_pulse_reg && (CPHA || bit_cnt_reg != '0)) begin
        spi_miso     <= tx_shift_reg[DW-1];
        tx_shift_reg <= tx_shift_reg << 1;
      end
      if (state_reg == RD && re_pipe_reg[1]) begin
        if (CPHA == 1'b0) begin
          spi_miso     <= bus_rdata[DW-1];
          tx_shift_reg <= bus_rdata << 1;
        end else begin
          tx_shift_reg <= bus_rdata;
        end
      end
      if (word_done) begin
        case (state_reg)
          CMD: begin
            bus_addr <= rx_word[AW-1:0];
            if (rx_word[DW-1]) begin
              state_reg <= RD;
              bus_re    <= 1'b1;
            end else begin
              state_reg <= WR;
            end
          end
          WR: begin
            bus_we    <= 1'b1;
            bus_wdata <= rx_word;
          end
          RD: begin
            bus_addr <= bus_addr + ADDR_INC;
            bus_re   <= 1'b1;
          end
          default: ;
        endcase
      end
      if (cs_fall_reg) begin
        state_reg    <= CMD;
        bit_cnt_reg  <= '0;
        tx_shift_reg <= '0;
        spi_miso     <= 1'b0;
      end
      // A word finishing on the same cycle as CS rise has already strobed above and is not an error.
      if (cs_rise_reg && state_reg != IDLE) begin
        if (cnt_next != '0)
          frame_err <= 1'b1;
        state_reg   <= IDLE;
        bit_cnt_reg <= '0;
        spi_miso    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_regif.sv
// Randomised bench for spi_regif: three instances (mode 0 / mode 3 at 8 bits, mode 1 at 16 bits)
// driven by a bit-level SPI master and checked against a frame-level transaction model.
`timescale 1ns/1ps
module tb_spi_regif;

  localparam int NI = 3;
  localparam int H  = 80;  // half SPI period in ns (8 system clocks)
`ifdef SPI_REGIF_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic sclk [NI];
  logic csn  [NI];
  logic mosi [NI];
  logic miso_w [NI];
  logic oe_w   [NI];
  logic we_w   [NI];
  logic re_w   [NI];
  logic ferr_w [NI];
  logic [15:0] addr_w  [NI];
  logic [15:0] wdata_w [NI];

  logic [6:0]  a_addr, b_addr;
  logic [11:0] c_addr;
  logic [7:0]  a_wdata, b_wdata, a_rdata, b_rdata;
  logic [15:0] c_wdata, c_rdata;

  logic [15:0] mem [4096];

  spi_regif #(.DW(8), .AW(7), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .spi_clk(sclk[0]), .spi_cs_n(csn[0]), .spi_mosi(mosi[0]),
    .spi_miso(miso_w[0]), .spi_miso_oe(oe_w[0]), .bus_addr(a_addr), .bus_wdata(a_wdata),
    .bus_we(we_w[0]), .bus_re(re_w[0]), .bus_rdata(a_rdata), .frame_err(ferr_w[0]));

  spi_regif #(.DW(8), .AW(7), .CPOL(1'b1), .CPHA(1'b1)) u_m3 (
    .clk(clk), .rst_n(rst_n), .spi_clk(sclk[1]), .spi_cs_n(csn[1]), .spi_mosi(mosi[1]),
    .spi_miso(miso_w[1]), .spi_miso_oe(oe_w[1]), .bus_addr(b_addr), .bus_wdata(b_wdata),
    .bus_we(we_w[1]), .bus_re(re_w[1]), .bus_rdata(b_rdata), .frame_err(ferr_w[1]));

  spi_regif #(.DW(16), .AW(12), .CPOL(1'b0), .CPHA(1'b1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .spi_clk(sclk[2]), .spi_cs_n(csn[2]), .spi_mosi(mosi[2]),
    .spi_miso(miso_w[2]), .spi_miso_oe(oe_w[2]), .bus_addr(c_addr), .bus_wdata(c_wdata),
    .bus_we(we_w[2]), .bus_re(re_w[2]), .bus_rdata(c_rdata), .frame_err(ferr_w[2]));

  assign addr_w[0]  = {9'h0, a_addr};
  assign addr_w[1]  = {9'h0, b_addr};
  assign addr_w[2]  = {4'h0, c_addr};
  assign wdata_w[0] = {8'h0, a_wdata};
  assign wdata_w[1] = {8'h0, b_wdata};
  assign wdata_w[2] = c_wdata;

  // Register bus slave: read data valid exactly two cycles after the strobe, zero otherwise.
  logic        re_p1 [NI];
  logic        re_p2 [NI];
  logic [11:0] ad_p1 [NI];
  logic [11:0] ad_p2 [NI];
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        re_p1[i] <= 1'b0; re_p2[i] <= 1'b0; ad_p1[i] <= '0; ad_p2[i] <= '0;
      end else begin
        re_p1[i] <= re_w[i]; re_p2[i] <= re_p1[i];
        ad_p1[i] <= addr_w[i][11:0]; ad_p2[i] <= ad_p1[i];
      end
    end
  end
  assign a_rdata = re_p2[0] ? mem[ad_p2[0]][7:0] : 8'h00;
  assign b_rdata = re_p2[1] ? mem[ad_p2[1]][7:0] : 8'h00;
  assign c_rdata = re_p2[2] ? mem[ad_p2[2]]      : 16'h0000;

  // Bus monitor: every strobe is logged tagged with its instance.
  logic [31:0] obs_wr [$];
  logic [31:0] obs_rd [$];
  int ferr_seen = 0;
  int overlap   = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        if (we_w[i]) obs_wr.push_back({4'(i), addr_w[i][11:0], wdata_w[i]});
        if (re_w[i]) obs_rd.push_back({4'(i), addr_w[i][11:0], 16'h0000});
        if (we_w[i] && re_w[i]) overlap++;
        if (ferr_w[i]) ferr_seen++;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int dw_of(input int i);
    return (i == 2) ? 16 : 8;
  endfunction
  function automatic int aw_of(input int i);
    return (i == 2) ? 12 : 7;
  endfunction
  function automatic bit cpol_of(input int i);
    return (i == 1);
  endfunction
  function automatic bit cpha_of(input int i);
    return (i != 0);
  endfunction

  // One word (or the first nbits of it) MSB first; cs_end raises CS together with the final sample edge.
  task automatic spi_word(input int inst, input logic [15:0] word, input int nbits,
                          input bit cs_end, output logic [15:0] rx);
    int  dw;
    bit  cpol, cpha;
    dw   = dw_of(inst);
    cpol = cpol_of(inst);
    cpha = cpha_of(inst);
    rx   = '0;
    for (int b = 0; b < nbits; b++) begin
      if (!cpha) begin
        mosi[inst] = word[dw-1-b];
        #H;
        sclk[inst] = ~cpol;
        rx = {rx[14:0], miso_w[inst]};
        #H;
        sclk[inst] = cpol;
      end else begin
        sclk[inst] = ~cpol;
        mosi[inst] = word[dw-1-b];
        #H;
        sclk[inst] = cpol;
        rx = {rx[14:0], miso_w[inst]};
        if (cs_end && b == nbits - 1) csn[inst] = 1'b1;
        else #H;
      end
    end
  endtask

  logic [15:0] tx_q [$];
  logic [15:0] rx_q [$];

  // Drive the frame in tx_q (plus an optional partial trailing word) and compare with the transaction model.
  task automatic run_frame(input int inst, input int partial, input bit cs_last);
    logic [15:0] rxw, junk, dmask, cmd;
    logic [31:0] ew [$];
    logic [31:0] er [$];
    logic [15:0] em [$];
    int n, dw, amask, a, f0;
    bit rd;
    n     = tx_q.size();
    dw    = dw_of(inst);
    dmask = (dw == 16) ? 16'hFFFF : 16'h00FF;
    amask = (1 << aw_of(inst)) - 1;
    obs_wr.delete();
    obs_rd.delete();
    rx_q.delete();
    f0 = ferr_seen;

    csn[inst] = 1'b0;
    #H;
    for (int w = 0; w < n; w++) begin
      spi_word(inst, tx_q[w], dw, cs_last && (w == n - 1), rxw);
      rx_q.push_back(rxw & dmask);
    end
    if (partial > 0) spi_word(inst, 16'($urandom), partial, 1'b0, junk);
    if (!cs_last) begin
      #H;
      csn[inst] = 1'b1;
    end
    #400;

    cmd = tx_q[0];
    rd  = cmd[dw-1];
    a   = int'(cmd) & amask;
    em.push_back(16'h0000);
    if (rd) begin
      for (int k = 0; k < n; k++)
        er.push_back({4'(inst), 12'((a + k*INC) & amask), 16'h0000});
      for (int i = 1; i < n; i++)
        em.push_back(mem[12'((a + (i-1)*INC) & amask)] & dmask);
    end else begin
      for (int k = 0; k < n - 1; k++) begin
        ew.push_back({4'(inst), 12'((a + k*INC) & amask), tx_q[k+1] & dmask});
        em.push_back(16'h0000);
      end
    end

    check("wr_count", obs_wr.size(), ew.size());
    for (int k = 0; k < ew.size() && k < obs_wr.size(); k++) check("wr_txn", obs_wr[k], ew[k]);
    check("rd_count", obs_rd.size(), er.size());
    for (int k = 0; k < er.size() && k < obs_rd.size(); k++) check("rd_txn", obs_rd[k], er[k]);
    for (int k = 0; k < n; k++) check($sformatf("miso_w%0d", k), rx_q[k], em[k]);
    check("frame_err", ferr_seen - f0, (partial > 0) ? 1 : 0);
    $display("frame inst=%0d cmd=%h words=%0d partial=%0d cs_last=%0d wr=%0d rd=%0d",
             inst, cmd, n, partial, cs_last, obs_wr.size(), obs_rd.size());
  endtask

  initial begin
    logic [15:0] junk;
    int inst, nw, partial, f0;
    bit cs_last;
    logic [15:0] dmask;

    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      sclk[i] = cpol_of(i);
      csn[i]  = 1'b1;
      mosi[i] = 1'b0;
    end
    #23;
    for (int i = 0; i < NI; i++) begin
      check("rst_miso", miso_w[i], 0);
      check("rst_oe", oe_w[i], 0);
      check("rst_we", we_w[i], 0);
      check("rst_re", re_w[i], 0);
      check("rst_ferr", ferr_w[i], 0);
      check("rst_addr", addr_w[i], 0);
      check("rst_wdata", wdata_w[i], 0);
    end
    #30 rst_n = 1'b1;
    #200;

    // Directed frames
    tx_q = '{16'h05, 16'hA1, 16'hB2};
    run_frame(0, 0, 1'b0);
    mem[12'h010] = 16'h003C;
    mem[12'h011] = 16'h005A;
    tx_q = '{16'h90, 16'h00, 16'h00};
    run_frame(1, 0, 1'b0);
    tx_q = '{16'h0ABC, 16'h1234};
    run_frame(2, 0, 1'b0);
    tx_q = '{16'h05};
    run_frame(0, 5, 1'b0);
    tx_q = '{16'h7F, 16'h01, 16'h02, 16'h03};
    run_frame(0, 0, 1'b0);
    tx_q = '{16'h03, 16'h44};
    run_frame(1, 0, 1'b1);
    tx_q = '{16'h8FFE, 16'h0000};
    run_frame(2, 0, 1'b1);

    // Reset in the middle of a read word: immediate abort, the rest of that frame is ignored.
    obs_wr.delete();
    obs_rd.delete();
    f0 = ferr_seen;
    csn[1] = 1'b0;
    #H;
    spi_word(1, 16'h0090, 8, 1'b0, junk);
    spi_word(1, 16'h00AA, 3, 1'b0, junk);
    #(H/2);
    rst_n = 1'b0;
    #1;
    check("abort_oe", oe_w[1], 0);
    check("abort_miso", miso_w[1], 0);
    check("abort_re", re_w[1], 0);
    check("abort_rd_before", obs_rd.size(), 1);
    obs_rd.delete();
    #47 rst_n = 1'b1;
    spi_word(1, 16'h0055, 5, 1'b0, junk);
    spi_word(1, 16'h0033, 8, 1'b0, junk);
    #H;
    csn[1] = 1'b1;
    #400;
    check("abort_wr_after", obs_wr.size(), 0);
    check("abort_rd_after", obs_rd.size(), 0);
    check("abort_ferr", ferr_seen - f0, 0);
    $display("frame inst=1 reset abort mid-read");
    tx_q = '{16'h91, 16'h00};
    run_frame(1, 0, 1'b0);

    // Randomised frames
    for (int f = 0; f < 30; f++) begin
      inst  = $urandom_range(0, 2);
      dmask = (dw_of(inst) == 16) ? 16'hFFFF : 16'h00FF;
      nw    = $urandom_range(1, 4);
      tx_q.delete();
      for (int w = 0; w < nw; w++) tx_q.push_back(16'($urandom) & dmask);
      partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dw_of(inst) - 1) : 0;
      cs_last = cpha_of(inst) && (partial == 0) && ($urandom_range(0, 2) == 0);
      run_frame(inst, partial, cs_last);
    end

    check("we_re_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
